// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: state encoding, command codes and default dummy byte for spi_cmd_ctrl
package spi_cmd_pkg;
  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_WR, ADDR_RD, WDATA, RD_WAIT, RDATA, STATUS, DRAIN
  } state_t;
  localparam logic [7:0] CMD_WRITE          = 8'h02;
  localparam logic [7:0] CMD_READ           = 8'h03;
  localparam logic [7:0] CMD_STATUS         = 8'h05;
  localparam logic [7:0] DEFAULT_DUMMY_BYTE = 8'hFF;
endpackage

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI byte command sequencer driving a register port; define SPI_CMD_CTRL_ERRCNT_EN for the saturating error counter
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [7:0]  STATUS_ID  = 8'hA5,
  parameter logic [7:0]  DUMMY_BYTE = DEFAULT_DUMMY_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);
  state_t state, state_nx;
  logic [7:0] status_val;
  logic byte_ok, cmd_tx, rd_cap, addr_ld;
  always_comb begin
    byte_ok  = rx_valid && !frame_start;
    cmd_tx   = state == CMD && byte_ok && rx_byte != CMD_WRITE && rx_byte != CMD_READ;
    rd_cap   = state == RD_WAIT && !reg_re && !frame_end && !frame_start;
    addr_ld  = (state == ADDR_WR || state == ADDR_RD) && byte_ok;
    state_nx = state;
    case (state)
      CMD:           state_nx = !rx_valid ? CMD :
                                rx_byte == CMD_WRITE  ? ADDR_WR :
                                rx_byte == CMD_READ   ? ADDR_RD :
                                rx_byte == CMD_STATUS ? STATUS : DRAIN;
      ADDR_WR:       state_nx = rx_valid ? WDATA : ADDR_WR;
      ADDR_RD, RDATA: state_nx = rx_valid ? RD_WAIT : state;
      RD_WAIT:       state_nx = reg_re ? RD_WAIT : RDATA;
      default:       state_nx = state;
    endcase
    state_nx = frame_start ? CMD : frame_end ? IDLE : state_nx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte   <= DUMMY_BYTE;
      tx_load   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we  <= state == WDATA && byte_ok;
      reg_re  <= (state == ADDR_RD || state == RDATA) && byte_ok;
      tx_load <= frame_start || cmd_tx || rd_cap;
      if (frame_start || cmd_tx)
        tx_byte <= (frame_start || rx_byte == CMD_STATUS) ? status_val : DUMMY_BYTE;
      else if (rd_cap)
        tx_byte <= reg_rdata;
      if (addr_ld)
        reg_addr <= rx_byte[ADDR_W-1:0];
      else if (reg_we || rd_cap)
        reg_addr <= reg_addr + ADDR_W'(1);
      if (state == WDATA && byte_ok)
        reg_wdata <= rx_byte;
    end
  end
`ifdef SPI_CMD_CTRL_ERRCNT_EN
  logic [7:0] err_cnt;
  logic err_inc;
  assign err_inc = (frame_start && state != IDLE) ||
                   (frame_end && (state == ADDR_WR || state == ADDR_RD)) ||
                   (cmd_tx && rx_byte != CMD_STATUS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                          err_cnt <= '0;
    else if (frame_end && !frame_start && state == STATUS) err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF)                err_cnt <= err_cnt + 8'd1;
  assign status_val = err_cnt;
`else
  assign status_val = STATUS_ID;
`endif
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind the SPI slave byte interface. It consumes received-byte strobes and frame start/end events, decodes a command/address/data protocol, and drives a simple register-file port. It also loads the slave's transmit byte so that read data and status are returned on MISO. It sits between the SPI slave shift logic and the local register bank.

Parameters:
ADDR_W, 8, register address width; address wraps modulo 2^ADDR_W
STATUS_ID, 8'hA5, status byte returned when the error counter is compiled out
DUMMY_BYTE, 8'hFF, tx byte for unknown commands and idle filler

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, SSEL falling edge (synchronised)
frame_end  in  1  one-cycle pulse, SSEL rising edge (synchronised)
rx_valid  in  1  one-cycle pulse, a full byte has been received
rx_byte  in  8  received byte, valid with rx_valid
tx_byte  out  8  byte for the slave to shift out, held until the next tx_load
tx_load  out  1  one-cycle pulse, tx_byte updated
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
busy  out  1  high while a frame is active (state != IDLE)

Behaviour:
- Reset: state IDLE; tx_byte=DUMMY_BYTE; tx_load=0; reg_addr=0; reg_wdata=0; reg_we=0; reg_re=0; busy=0.
- Command codes (package constants): CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_STATUS=8'h05.
- States: IDLE, CMD, ADDR_WR, ADDR_RD, WDATA, RD_WAIT, RDATA, STATUS, DRAIN.
- IDLE:
  - frame_start -> CMD.
  - Same cycle: tx_byte=status value, tx_load=1.
- CMD, on rx_valid:
  - 02 -> ADDR_WR.
  - 03 -> ADDR_RD.
  - 05 -> STATUS; tx_byte=status value, tx_load pulse.
  - Other codes -> DRAIN; tx_byte=DUMMY_BYTE, tx_load pulse.
- ADDR_WR, on rx_valid: reg_addr<=rx_byte[ADDR_W-1:0] -> WDATA.
- WDATA, on rx_valid:
  - reg_wdata<=rx_byte and reg_we=1 in the next cycle, using the current reg_addr.
  - In the cycle after reg_we, reg_addr increments.
  - Stays in WDATA (burst).
- ADDR_RD, on rx_valid:
  - reg_addr<=rx_byte, then reg_re pulses in the next cycle -> RD_WAIT.
- RD_WAIT (1 cycle): capture reg_rdata into tx_byte, tx_load=1, reg_addr++ -> RDATA.
- RDATA, on rx_valid (dummy byte from master): reg_re=1 at the current reg_addr -> RD_WAIT.
- Latency: rx_valid to tx_load is 3 cycles for a read (rx_valid, reg_re, rdata capture). This is well inside one SCK bit time at the intended clock ratio.
- STATUS / DRAIN: rx_valid is ignored; tx_byte is held.
- Address wrap: at 2^ADDR_W-1 the increment goes to 0; there is no error.
- frame_end in any state:
  - Goes to IDLE next cycle, busy=0.
  - A strobe already scheduled (reg_we/reg_re) still completes.
  - Pending read data is not loaded into tx_byte.
- rx_valid and frame_end in the same cycle: the byte is processed first (a write is committed), then IDLE.
- frame_start while not IDLE (missed frame_end): restart at CMD. Counts as a truncated-frame error.
- reg_we and reg_re are never asserted in the same cycle.
- Status value:
  - With the feature: {err_cnt}.
  - Without the feature: STATUS_ID.

Optional Feature:
SPI_CMD_CTRL_ERRCNT_EN
- Defined: 8-bit saturating err_cnt (stops at 8'hFF), reset 0. It increments on:
  - each unknown command byte;
  - each frame_end in ADDR_WR or ADDR_RD (truncated frame);
  - each frame_start outside IDLE.
- Defined: the status value is err_cnt. A STATUS command clears err_cnt on the frame_end of that frame.
- Undefined: no counter logic; the status value is STATUS_ID.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum typedef;
  - CMD_WRITE, CMD_READ, CMD_STATUS;
  - the default DUMMY_BYTE.
- Single module. No sub-module; the error counter is inline under the macro.

Test Plan:
- Write burst: frame_start; bytes 02,10,AA,BB; frame_end -> reg_we at addr 10 data AA, then at addr 11 data BB; exactly 2 reg_we pulses.
- Read burst: regs 20=5C, 21=3E; bytes 03,20,FF,FF -> tx_byte 5C loaded 3 cycles after the address rx_valid, then 3E; reg_re at 20 and 21.
- Wrap: write 02,FF,01,02 -> writes at addr FF then 00.
- Status: frame 05 -> tx_byte A5 (feature off). With the feature on, after one bad command 7E: the next frame returns 01, and a following frame returns 00.
- Abort: frame_end immediately after 03,40 -> reg_re still issued, no tx_load of the data, busy=0 the next cycle, state IDLE.
- Reset mid-burst: assert rst_n=0 during WDATA -> all outputs return to reset values immediately; no reg_we after release.
